// File: rtl/pcs_alignement_marker_insert_tx.sv
// rtl/pcs_alignement_marker_insert_tx.sv - 40GBASE-R transmit alignment marker inserter with per-lane BIP
module pcs_alignement_marker_insert_tx #(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int GAP_N   = 16383
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [LANE_N*BLOCK_W-1:0]   block_i,
    output logic                        valid_o,
    output logic [LANE_N*BLOCK_W-1:0]   block_o,
    output logic                        marker_v_o
);

    localparam int CW = $clog2(GAP_N + 1);
    localparam logic [CW-1:0] GAP_MAX = CW'(GAP_N);

    // Only four marker encodings exist and the marker layout is built for 66-bit blocks.
    generate
        if (LANE_N > 4) begin : g_lane_check
            $error("pcs_alignement_marker_insert_tx: LANE_N > 4 is unsupported");
        end
        if (BLOCK_W != 66) begin : g_width_check
            $error("pcs_alignement_marker_insert_tx: BLOCK_W must be 66");
        end
    endgenerate

    // Per-lane marker code, packed as {M0, M1, M2}.
    function automatic logic [23:0] am_code(input int lane);
        logic [23:0] code;
        case (lane)
            0:       code = 24'h907647;
            1:       code = 24'hF0C4E6;
            2:       code = 24'hC5659B;
            3:       code = 24'hA2793D;
            default: code = 24'h000000;
        endcase
        return code;
    endfunction

    // Clause 82 BIP fold: payload bit 2+j+8k lands in BIP bit j; the sync
    // header bits land in BIP bits 3 and 4.
    function automatic logic [7:0] fold(input logic [BLOCK_W-1:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                r[j] = r[j] ^ b[2 + j + 8*k];
            end
        end
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    logic [CW-1:0]              cnt_q;
    logic [7:0]                 bip_q [LANE_N];
    logic [7:0]                 bip_next [LANE_N];
    logic [LANE_N*BLOCK_W-1:0]  marker_blocks;
    logic                       is_marker;
    logic                       accept;

    // The gap counter parked at GAP_N means this cycle emits markers.
    assign is_marker = (cnt_q == GAP_MAX);
    assign ready_o   = nreset & ~is_marker;
    assign accept    = ~is_marker & valid_i;

    // Build the marker for every lane from the accumulated BIP and fold in
    // the data blocks being accepted this cycle.
    always_comb begin
        marker_blocks = '0;
        for (int l = 0; l < LANE_N; l++) begin
            logic [23:0] code;
            logic [7:0]  m0, m1, m2, bip3;
            code = am_code(l);
            m0   = code[23:16];
            m1   = code[15:8];
            m2   = code[7:0];
            bip3 = bip_q[l];
            marker_blocks[l*BLOCK_W +: BLOCK_W] =
                {~bip3, ~m2, ~m1, ~m0, bip3, m2, m1, m0, 2'b01};
            bip_next[l] = bip_q[l] ^ fold(block_i[l*BLOCK_W +: BLOCK_W]);
        end
    end

    // Gap counter, registered outputs and BIP accumulators.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q      <= GAP_MAX;
            valid_o    <= 1'b0;
            marker_v_o <= 1'b0;
            block_o    <= '0;
            for (int l = 0; l < LANE_N; l++) begin
                bip_q[l] <= 8'h00;
            end
        end else if (is_marker) begin
            cnt_q      <= '0;
            valid_o    <= 1'b1;
            marker_v_o <= 1'b1;
            block_o    <= marker_blocks;
            // The marker's own fold is always 8'h08, so start the next period there.
            for (int l = 0; l < LANE_N; l++) begin
                bip_q[l] <= 8'h08;
            end
        end else if (accept) begin
            cnt_q      <= cnt_q + CW'(1);
            valid_o    <= 1'b1;
            marker_v_o <= 1'b0;
            block_o    <= block_i;
            for (int l = 0; l < LANE_N; l++) begin
                bip_q[l] <= bip_next[l];
            end
        end else begin
            // Stall: nothing out, block_o keeps its last value.
            valid_o    <= 1'b0;
            marker_v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcs_alignement_marker_insert_tx.sv
// tb/tb_pcs_alignement_marker_insert_tx.sv - directed bench for the alignment marker inserter
module tb_pcs_alignement_marker_insert_tx;

    localparam int BW = 66;
    localparam int LN = 4;
    localparam int GN = 4;
    localparam logic [BW-1:0] ZB = 66'h2;

    logic               clk = 1'b0;
    logic               nreset = 1'b0;
    logic               valid_i = 1'b0;
    logic               ready_o;
    logic [LN*BW-1:0]   block_i = '0;
    logic               valid_o;
    logic [LN*BW-1:0]   block_o;
    logic               marker_v_o;

    int n_cmp = 0;
    int n_bad = 0;

    pcs_alignement_marker_insert_tx #(
        .BLOCK_W (BW),
        .LANE_N  (LN),
        .GAP_N   (GN)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .block_i    (block_i),
        .valid_o    (valid_o),
        .block_o    (block_o),
        .marker_v_o (marker_v_o)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] am_exp(input int lane, input logic [7:0] b3);
        logic [7:0] m0, m1, m2;
        case (lane)
            0:       begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
            1:       begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
            2:       begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
            default: begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
        endcase
        return {~b3, ~m2, ~m1, ~m0, b3, m2, m1, m0, 2'b01};
    endfunction

    function automatic logic [7:0] fold(input logic [BW-1:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++)
                r[j] = r[j] ^ b[2 + j + 8*k];
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    task automatic test_reset();
        logic [BW-1:0] lane0_exp;
        lane0_exp = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01};
        nreset = 1'b0; valid_i = 1'b1; block_i = {LN{ZB}};
        repeat (3) @(negedge clk);
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (marker_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_marker_v: got %b want 0", marker_v_o); end
        n_cmp++; if (block_o !== '0) begin n_bad++; $display("FAIL reset_block: got %h want 0", block_o); end
        nreset = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL first_marker_ready: got %b want 0", ready_o); end
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b1 || marker_v_o !== 1'b1) begin n_bad++; $display("FAIL first_marker_flags: got v=%b m=%b want 1 1", valid_o, marker_v_o); end
        n_cmp++; if (block_o[0 +: BW] !== lane0_exp) begin n_bad++; $display("FAIL first_marker_lane0: got %h want %h", block_o[0 +: BW], lane0_exp); end
        for (int l = 1; l < LN; l++) begin
            n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, 8'h00)) begin n_bad++; $display("FAIL first_marker_lane%0d: got %h want %h", l, block_o[l*BW +: BW], am_exp(l, 8'h00)); end
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < GN; i++) begin
            n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL gap_ready%0d: got %b want 1", i, ready_o); end
            valid_i = 1'b1; block_i = {LN{ZB}};
            @(negedge clk);
            n_cmp++; if (valid_o !== 1'b1 || marker_v_o !== 1'b0) begin n_bad++; $display("FAIL gap_data_flags%0d: got v=%b m=%b want 1 0", i, valid_o, marker_v_o); end
            n_cmp++; if (block_o !== {LN{ZB}}) begin n_bad++; $display("FAIL gap_data%0d: got %h want %h", i, block_o, {LN{ZB}}); end
        end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL gap_marker_ready: got %b want 0", ready_o); end
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b1 || marker_v_o !== 1'b1) begin n_bad++; $display("FAIL gap_marker_flags: got v=%b m=%b want 1 1", valid_o, marker_v_o); end
        for (int l = 0; l < LN; l++) begin
            n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, 8'h08)) begin n_bad++; $display("FAIL gap_marker_lane%0d: got %h want %h", l, block_o[l*BW +: BW], am_exp(l, 8'h08)); end
        end
    endtask

    task automatic test_bip_bit();
        logic [LN*BW-1:0] blk;
        for (int i = 0; i < GN; i++) begin
            blk = {LN{ZB}};
            if (i == 1) blk[2*BW +: BW] = 66'h6;
            valid_i = 1'b1; block_i = blk;
            @(negedge clk);
            n_cmp++; if (block_o !== blk || valid_o !== 1'b1) begin n_bad++; $display("FAIL bip_bit_data%0d: got %h v=%b want %h v=1", i, block_o, valid_o, blk); end
        end
        @(negedge clk);
        n_cmp++; if (marker_v_o !== 1'b1) begin n_bad++; $display("FAIL bip_bit_marker_v: got %b want 1", marker_v_o); end
        for (int l = 0; l < LN; l++) begin
            logic [7:0] b3;
            b3 = (l == 2) ? 8'h09 : 8'h08;
            n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, b3)) begin n_bad++; $display("FAIL bip_bit_lane%0d: got %h want %h", l, block_o[l*BW +: BW], am_exp(l, b3)); end
        end
    endtask

    task automatic test_stall();
        logic [LN*BW-1:0] held;
        logic [BW-1:0]    dat [7];
        logic             pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        dat[0] = {8'hA1, 56'h0, 2'b10};
        dat[3] = {8'h5C, 56'h0, 2'b10};
        dat[4] = {8'hA1, 56'h0, 2'b10};
        dat[6] = {8'h5C, 56'h0, 2'b10};
        dat[1] = '1; dat[2] = '1; dat[5] = '1;
        held = '0;
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_ready%0d: got %b want 1", i, ready_o); end
            valid_i = pat[i]; block_i = {LN{dat[i]}};
            @(negedge clk);
            if (pat[i]) held = {LN{dat[i]}};
            n_cmp++; if (valid_o !== pat[i] || marker_v_o !== 1'b0) begin n_bad++; $display("FAIL stall_flags%0d: got v=%b m=%b want %b 0", i, valid_o, marker_v_o, pat[i]); end
            n_cmp++; if (block_o !== held) begin n_bad++; $display("FAIL stall_block%0d: got %h want %h", i, block_o, held); end
        end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_marker_ready: got %b want 0", ready_o); end
        valid_i = 1'b1; block_i = {LN{ZB}};
        @(negedge clk);
        n_cmp++; if (marker_v_o !== 1'b1 || valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_marker_flags: got v=%b m=%b want 1 1", valid_o, marker_v_o); end
        for (int l = 0; l < LN; l++) begin
            n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, 8'h08)) begin n_bad++; $display("FAIL stall_marker_lane%0d: got %h want %h", l, block_o[l*BW +: BW], am_exp(l, 8'h08)); end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; block_i = {LN{66'h6}};
            @(negedge clk);
            n_cmp++; if (valid_o !== 1'b1 || block_o !== {LN{66'h6}}) begin n_bad++; $display("FAIL mid_reset_data%0d: got v=%b %h want v=1 %h", i, valid_o, block_o, {LN{66'h6}}); end
        end
        nreset = 1'b0;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready_low: got %b want 0", ready_o); end
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0 || marker_v_o !== 1'b0 || ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_state: got v=%b m=%b r=%b want 0 0 0", valid_o, marker_v_o, ready_o); end
        nreset = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_decide_ready: got %b want 0", ready_o); end
        @(negedge clk);
        n_cmp++; if (marker_v_o !== 1'b1 || valid_o !== 1'b1) begin n_bad++; $display("FAIL mid_reset_marker_flags: got v=%b m=%b want 1 1", valid_o, marker_v_o); end
        for (int l = 0; l < LN; l++) begin
            n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, 8'h00)) begin n_bad++; $display("FAIL mid_reset_marker_lane%0d: got %h want %h", l, block_o[l*BW +: BW], am_exp(l, 8'h00)); end
        end
    endtask

    task automatic test_random();
        logic [7:0]       bip_m [LN];
        logic [LN*BW-1:0] blk;
        for (int l = 0; l < LN; l++) bip_m[l] = 8'h08;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < GN; i++) begin
                for (int l = 0; l < LN; l++) begin
                    logic [BW-1:0] r;
                    r = {$urandom, $urandom, $urandom};
                    blk[l*BW +: BW] = r;
                    bip_m[l] = bip_m[l] ^ fold(r);
                end
                valid_i = 1'b1; block_i = blk;
                @(negedge clk);
                n_cmp++; if (valid_o !== 1'b1 || marker_v_o !== 1'b0 || block_o !== blk) begin n_bad++; $display("FAIL rand_data p%0d i%0d: got v=%b m=%b %h want 1 0 %h", p, i, valid_o, marker_v_o, block_o, blk); end
            end
            block_i = {LN{{$urandom, $urandom, $urandom}}};
            @(negedge clk);
            n_cmp++; if (marker_v_o !== 1'b1 || valid_o !== 1'b1) begin n_bad++; $display("FAIL rand_marker_flags p%0d: got v=%b m=%b want 1 1", p, valid_o, marker_v_o); end
            for (int l = 0; l < LN; l++) begin
                n_cmp++; if (block_o[l*BW +: BW] !== am_exp(l, bip_m[l])) begin n_bad++; $display("FAIL rand_marker p%0d lane%0d: got %h want %h", p, l, block_o[l*BW +: BW], am_exp(l, bip_m[l])); end
                bip_m[l] = 8'h08;
            end
        end
    endtask

    initial begin
        test_reset();
        test_gap();
        test_bip_bit();
        test_stall();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
